// File: rtl/i2s_receive_pkg.sv
// Shared definitions for the I2S receiver: channel encodings, synchroniser
// depth and a constant-evaluable ceil(log2) helper.
package i2s_receive_pkg;

  localparam logic WS_LEFT  = 1'b0;
  localparam logic WS_RIGHT = 1'b1;

  localparam int unsigned SYNC_STAGES = 2;

  // ceil(log2(value)), never less than 1 so it can size any vector
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    result = 1;
    while ((64'd1 << result) < 64'(value)) result = result + 1;
    return result;
  endfunction

endpackage

// File: rtl/i2s_receive_if.sv
// AXI4-Stream beat bus carrying received samples.
//   M_AXIS_TDATA  : sample word, MSB-aligned
//   M_AXIS_TVALID : beat valid
//   M_AXIS_TLAST  : 1 = right channel (end of frame)
//   M_AXIS_TREADY : downstream ready
interface i2s_receive_if #(
  parameter int unsigned DATA_WIDTH = 32
);
  logic [DATA_WIDTH-1:0] M_AXIS_TDATA;
  logic                  M_AXIS_TVALID;
  logic                  M_AXIS_TLAST;
  logic                  M_AXIS_TREADY;

  modport master (
    output M_AXIS_TDATA,
    output M_AXIS_TVALID,
    output M_AXIS_TLAST,
    input  M_AXIS_TREADY
  );

  modport slave (
    input  M_AXIS_TDATA,
    input  M_AXIS_TVALID,
    input  M_AXIS_TLAST,
    output M_AXIS_TREADY
  );
endinterface

// File: rtl/i2s_rx_fifo.sv
// First-word-fall-through FIFO with a registered head entry.
//   clk, rst  : clock, asynchronous active-high reset
//   wr_en     : write request (accepted when not full, or full with a pop)
//   wr_data   : entry to write
//   rd_en     : pop request (ignored while empty)
//   rd_data   : registered head entry
//   empty     : registered, no head entry present
//   full      : all DEPTH entries occupied
//   free_cnt  : DEPTH minus occupied entries
module i2s_rx_fifo
  import i2s_receive_pkg::*;
#(
  parameter int unsigned WIDTH = 33,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             empty,
  output logic             full,
  output logic [CNT_W-1:0] free_cnt
);

  localparam int unsigned AW = clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CNT_W-1:0] count;

  logic             pop_c;
  logic             push_c;
  logic [CNT_W-1:0] count_after_pop_c;
  logic [CNT_W-1:0] count_n_c;
  logic [AW-1:0]    rd_ptr_n_c;
  logic [WIDTH-1:0] head_n_c;

  assign full     = (count == CNT_W'(DEPTH));
  assign free_cnt = CNT_W'(DEPTH) - count;

  // Head for the next cycle; a write into an otherwise empty FIFO bypasses mem
  always_comb begin
    pop_c             = rd_en && (count != '0);
    push_c            = wr_en && (!full || pop_c);
    count_after_pop_c = count - CNT_W'(pop_c);
    count_n_c         = count_after_pop_c + CNT_W'(push_c);
    rd_ptr_n_c        = rd_ptr + AW'(pop_c);
    head_n_c          = (count_after_pop_c == '0) ? wr_data : mem[rd_ptr_n_c];
  end

  always_ff @(posedge clk) begin
    if (push_c) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      rd_data <= '0;
      empty   <= 1'b1;
    end else begin
      wr_ptr <= wr_ptr + AW'(push_c);
      rd_ptr <= rd_ptr_n_c;
      count  <= count_n_c;
      empty  <= (count_n_c == '0);
      if (count_n_c != '0) rd_data <= head_n_c;
    end
  end

endmodule

// File: rtl/i2s_receive.sv
// I2S receiver: synchronises an externally clocked sck/ws/sd bus into the
// ACLK domain, deserialises MSB-first left/right words and emits one AXIS
// beat per channel (left TLAST=0, right TLAST=1) through a pair-aligned FIFO.
//   M_AXIS_ACLK   : system clock
//   M_AXIS_ARESET : asynchronous active-high reset
//   sck, ws, sd   : I2S bit clock, word select (0 = left), serial data
//   m_axis        : AXIS master (TDATA/TVALID/TLAST out, TREADY in)
//   overflow      : sticky, a frame was dropped
module i2s_receive
  import i2s_receive_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                  M_AXIS_ACLK,
  input  logic                  M_AXIS_ARESET,
  input  logic                  sck,
  input  logic                  ws,
  input  logic                  sd,
  i2s_receive_if.master         m_axis,
  output logic                  overflow
);

  localparam int unsigned CNT_W  = clog2(DATA_WIDTH + 1);
  localparam int unsigned IDX_W  = clog2(DATA_WIDTH);
  localparam int unsigned FREE_W = clog2(FIFO_DEPTH + 1);

  logic [SYNC_STAGES-1:0] sck_sync;
  logic [SYNC_STAGES-1:0] ws_sync;
  logic [SYNC_STAGES-1:0] sd_sync;
  logic                   sck_prev;

  logic                   ws_last;
  logic                   synced;
  logic                   drop_right;
  logic [CNT_W-1:0]       bit_cnt;
  logic [DATA_WIDTH-1:0]  word;

  logic                   ws_last_n;
  logic                   synced_n;
  logic                   drop_right_n;
  logic                   overflow_n;
  logic [CNT_W-1:0]       bit_cnt_n;
  logic [DATA_WIDTH-1:0]  word_n;

  logic                   sck_rise_c;
  logic                   ws_now_c;
  logic                   sd_now_c;
  logic                   boundary_c;
  logic                   store_c;
  logic [IDX_W-1:0]       bit_idx_c;
  logic [DATA_WIDTH-1:0]  word_done_c;
  logic                   push_c;

  logic [DATA_WIDTH:0]    fifo_rd_data;
  logic                   fifo_empty;
  logic                   fifo_full;
  logic [FREE_W-1:0]      fifo_free;

  assign sck_rise_c = sck_sync[SYNC_STAGES-1] & ~sck_prev;
  assign ws_now_c   = ws_sync[SYNC_STAGES-1];
  assign sd_now_c   = sd_sync[SYNC_STAGES-1];
  assign boundary_c = sck_rise_c && (ws_now_c != ws_last);
  assign bit_idx_c  = IDX_W'(DATA_WIDTH - 1) - IDX_W'(bit_cnt);

  // Bits past DATA_WIDTH are slot padding; a runt word (toggle at bit 0) stays zero
  assign store_c = (bit_cnt < CNT_W'(DATA_WIDTH)) && !(boundary_c && (bit_cnt == '0));

  // Current word with this cycle's bit merged in
  always_comb begin
    word_done_c = word;
    if (store_c) word_done_c[bit_idx_c] = sd_now_c;
  end

  // Deserialiser, frame alignment and pair-drop bookkeeping
  always_comb begin
    word_n       = word;
    bit_cnt_n    = bit_cnt;
    ws_last_n    = ws_last;
    synced_n     = synced;
    drop_right_n = drop_right;
    overflow_n   = overflow;
    push_c       = 1'b0;
    if (sck_rise_c) begin
      if (!boundary_c) begin
        word_n = word_done_c;
        if (bit_cnt < CNT_W'(DATA_WIDTH)) bit_cnt_n = bit_cnt + CNT_W'(1);
      end else begin
        word_n    = '0;
        bit_cnt_n = '0;
        ws_last_n = ws_now_c;
        if (ws_last == WS_RIGHT && ws_now_c == WS_LEFT) synced_n = 1'b1;
        if (synced) begin
          if (ws_last == WS_LEFT) begin
            // Admit a left word only if its right partner is guaranteed a slot
            if (fifo_free < FREE_W'(2)) begin
              drop_right_n = 1'b1;
              overflow_n   = 1'b1;
            end else begin
              push_c = 1'b1;
            end
          end else if (drop_right) begin
            drop_right_n = 1'b0;
          end else begin
            push_c = 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge M_AXIS_ACLK or posedge M_AXIS_ARESET) begin
    if (M_AXIS_ARESET) begin
      sck_sync   <= '0;
      ws_sync    <= '0;
      sd_sync    <= '0;
      sck_prev   <= 1'b0;
      ws_last    <= WS_LEFT;
      synced     <= 1'b0;
      drop_right <= 1'b0;
      overflow   <= 1'b0;
      bit_cnt    <= '0;
      word       <= '0;
    end else begin
      sck_sync   <= {sck_sync[SYNC_STAGES-2:0], sck};
      ws_sync    <= {ws_sync[SYNC_STAGES-2:0], ws};
      sd_sync    <= {sd_sync[SYNC_STAGES-2:0], sd};
      sck_prev   <= sck_sync[SYNC_STAGES-1];
      ws_last    <= ws_last_n;
      synced     <= synced_n;
      drop_right <= drop_right_n;
      overflow   <= overflow_n;
      bit_cnt    <= bit_cnt_n;
      word       <= word_n;
    end
  end

  i2s_rx_fifo #(
    .WIDTH (DATA_WIDTH + 1),
    .DEPTH (FIFO_DEPTH),
    .CNT_W (FREE_W)
  ) u_fifo (
    .clk      (M_AXIS_ACLK),
    .rst      (M_AXIS_ARESET),
    .wr_en    (push_c),
    .wr_data  ({ws_last, word_done_c}),
    .rd_en    (m_axis.M_AXIS_TREADY),
    .rd_data  (fifo_rd_data),
    .empty    (fifo_empty),
    .full     (fifo_full),
    .free_cnt (fifo_free)
  );

  assign m_axis.M_AXIS_TDATA  = fifo_rd_data[DATA_WIDTH-1:0];
  assign m_axis.M_AXIS_TLAST  = fifo_rd_data[DATA_WIDTH];
  assign m_axis.M_AXIS_TVALID = ~fifo_empty;

  // Pair admission already prevents writes into a full FIFO
  logic unused_full;
  assign unused_full = fifo_full;

endmodule

// File: doc/i2s_receive.md
Name: i2s_receive

Overview:
- I2S serial-to-AXI4-Stream receiver; the receive-side counterpart of the I2S transmitter.
- Samples an external sck/ws/sd bus (ADC/codec as bus master) in the ACLK domain and deserialises MSB-first left/right words.
- Emits one AXIS beat per channel: left beat TLAST=0, right beat TLAST=1, through a small frame-aligned FIFO.
- Feeds the visualizer sample path.

Parameters:
- DATA_WIDTH, 32, bits captured per channel word; also the TDATA width.
- FIFO_DEPTH, 4, output FIFO entries; power of two, minimum 2.

Ports:
- M_AXIS_ACLK  in  1  system clock; all logic in this domain.
- M_AXIS_ARESET  in  1  asynchronous, active-high reset.
- sck  in  1  I2S bit clock, asynchronous to ACLK.
- ws  in  1  I2S word select; 0 = left, 1 = right.
- sd  in  1  I2S serial data.
- M_AXIS_TDATA  out  DATA_WIDTH  received sample, MSB-aligned.
- M_AXIS_TVALID  out  1  beat valid.
- M_AXIS_TLAST  out  1  1 = right channel (end of frame).
- M_AXIS_TREADY  in  1  downstream ready.
- overflow  out  1  sticky; a frame was dropped.

Behaviour:
- Reset (asynchronous assert): TVALID=0, TLAST=0, TDATA=0, overflow=0, FIFO empty, synced=0, bit_cnt=0, shift register=0, synchroniser flops=0.
- Input sampling:
  - sck, ws and sd each pass through a 2-FF synchroniser.
  - sck_rise is a single-cycle pulse when synchronised sck goes 0->1.
  - ACLK must be at least 4x sck. Slower ACLK is out of scope and undefined.
- On each sck_rise, ws_now and sd_now are taken from the synchroniser outputs and compared with ws_last.
- ws_now == ws_last (mid-word):
  - If bit_cnt < DATA_WIDTH: write sd_now into word[DATA_WIDTH-1-bit_cnt] and increment bit_cnt.
  - If bit_cnt >= DATA_WIDTH: discard the bit (slot padding); bit_cnt saturates at DATA_WIDTH.
- ws_now != ws_last (word boundary, standard I2S one-bit delay):
  - This bit is the LSB of the word for channel ws_last. Store it under the same bit_cnt rule as mid-word.
  - The word is then complete. Unfilled low bits stay 0 (short slot gives an MSB-aligned, zero-padded word).
  - Push {TLAST=ws_last, word} when synced=1 and not drop-flagged.
  - Clear the word register and bit_cnt to 0. Update ws_last.
  - The next sck_rise carries the MSB of the new channel.
- Frame alignment:
  - synced is set at the first 1->0 ws boundary after reset, i.e. when a left word starts.
  - Every word before that point is discarded, so the first pushed beat is always a left word.
- Overflow and drop policy:
  - At a left-word completion, if FIFO free entries < 2: drop the left word, set drop_right, set overflow.
  - At the next right completion with drop_right set: drop the right word and clear drop_right.
  - As a result, the FIFO only ever holds complete L,R pairs, and a right word is never dropped alone.
  - overflow clears only on reset.
- Latency: a push occurs in the cycle of the boundary sck_rise. The FIFO writes on the next ACLK edge, and TVALID is high from that next cycle when the FIFO was empty.
- AXIS rules:
  - TDATA/TLAST are held stable while TVALID=1 and TREADY=0.
  - A pop occurs when TVALID && TREADY. The next entry appears in the following cycle, so back-to-back beats are possible.
- FIFO corner cases:
  - Simultaneous push and pop while full is legal: the pop frees the slot.
  - The free-count check for a left push uses the pre-pop count.
- Reset mid-word: all state returns to the reset state immediately. The partial word is lost, and output resumes at the next left-word start.
- Runt word (ws toggles with bit_cnt=0): push a zero word with the correct TLAST when synced.

Decomposition:
- Shared package/header holds:
  - localparam WS_LEFT=0, WS_RIGHT=1.
  - Synchroniser stage count, fixed at 2.
  - The clog2 helper.
- One sub-module, i2s_rx_fifo: synchronous FIFO of width DATA_WIDTH+1 and depth FIFO_DEPTH.
  - Ports: wr_en, wr_data, rd_en, rd_data, empty, full, free_cnt.
  - Async active-high reset.
  - Registered output, first-word-fall-through.

Test Plan:
- Basic frame: ACLK 100 MHz, sck 3.125 MHz, 32-bit slots, L=0xA5A5_0001, R=0x5A5A_8002, TREADY=1 -> beats (0xA5A50001, TLAST=0) then (0x5A5A8002, TLAST=1); overflow=0.
- Sync: reset released with ws=1 mid-right-word -> that word and any earlier ones are discarded; the first beat is the left word after the first ws 1->0 boundary.
- Short data: DATA_WIDTH=24, 32-bit slots, L=0x123456 followed by 8 padding bits of 1 -> TDATA=0x123456 (padding ignored).
- Backpressure: TREADY=0 for 3 frames, FIFO_DEPTH=4 -> frames 1-2 held; frame 3 is dropped as a pair; overflow=1. Raising TREADY then yields L1,R1,L2,R2 with TDATA/TLAST stable while stalled.
- Reset mid-word: assert reset at bit 10 of a left word -> TVALID=0 within one cycle. After release, no partial word is emitted and the next complete L,R pair is correct.
- Stall stability: TREADY toggling every cycle with random L/R data over 100 frames -> output stream equals input sequence exactly, with strictly alternating TLAST.
